// File: rtl/muxp_pkg.sv
// Shared types and bundle field positions for the project mux scheduler.
// Pure definitions: no logic, no latency, no flow control.
package muxp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RESET = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int IW_CLK     = 0;
    localparam int IW_RSTN    = 1;
    localparam int IW_UI_LSB  = 2;
    localparam int IW_UIO_LSB = 10;
    localparam int IW_W       = 18;

    localparam int OW_W       = 24;
    localparam int OW_UO_LSB  = 0;
    localparam int OW_UIO_LSB = 8;
    localparam int OW_OE_LSB  = 16;

endpackage

// File: rtl/proj_sched_ctrl_if.sv
// Host request/status and project-array bundles of the scheduler.
// master = host and project array side, slave = proj_sched_ctrl.
interface proj_sched_ctrl_if #(
    parameter int N_PROJ = 32
);
    import muxp_pkg::*;

    localparam int SEL_W = $clog2(N_PROJ);

    logic                     req_valid;
    logic [SEL_W-1:0]         req_sel;
    logic                     req_ready;
    logic                     sel_err;
    logic [SEL_W-1:0]         cur_sel;
    logic                     running;
    logic                     step_mode;
    logic                     step;
    logic [7:0]               ui_in;
    logic [7:0]               uio_in;
    logic [N_PROJ-1:0]        proj_ena;
    logic [IW_W-1:0]          proj_iw;
    logic [N_PROJ*OW_W-1:0]   proj_ow;
    logic [OW_W-1:0]          out_ow;

    modport master (
        output req_valid, req_sel, step_mode, step, ui_in, uio_in, proj_ow,
        input  req_ready, sel_err, cur_sel, running, proj_ena, proj_iw, out_ow
    );

    modport slave (
        input  req_valid, req_sel, step_mode, step, ui_in, uio_in, proj_ow,
        output req_ready, sel_err, cur_sel, running, proj_ena, proj_iw, out_ow
    );

endinterface

// File: rtl/proj_clk_gen.sv
// Project clock generator: free-running or single-step, registered output.
// Latency 1 cycle from step to rising proj_clk; steps during a period are dropped.
module proj_clk_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic force_low,
    input  logic step_mode,
    input  logic step,
    output logic proj_clk,
    output logic period_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          clk_q;
    logic          step_q;
    logic          busy;
    logic          last;
    logic          stepping;

    assign last     = (cnt == CW'(DIV - 1));
    // Step mode is only honoured in RUN; the reset sequence is always free-running.
    assign stepping = run & step_q;
    assign proj_clk = clk_q;

    always_comb begin
        period_done = 1'b0;
        if (!force_low) begin
            period_done = stepping ? (busy & ~clk_q & last) : (clk_q & last);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            step_q <= 1'b0;
            busy   <= 1'b0;
        end else if (force_low) begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            busy   <= 1'b0;
            step_q <= step_mode;
        end else if (stepping) begin
            if (!busy) begin
                cnt <= '0;
                if (step) begin
                    busy  <= 1'b1;
                    clk_q <= 1'b1;
                end else begin
                    step_q <= step_mode;
                end
            end else if (last) begin
                cnt <= '0;
                if (clk_q) begin
                    clk_q <= 1'b0;
                end else begin
                    busy   <= 1'b0;
                    step_q <= step_mode;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (last) begin
            cnt   <= '0;
            clk_q <= ~clk_q;
            // A falling edge closes a free-running period: the mode may change here.
            if (clk_q) begin
                step_q <= step_mode;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/proj_sched_ctrl.sv
// Keeps one wrapped project enabled, sequencing drain/reset/run on every switch.
// Outputs registered (1 cycle); req_ready low during DRAIN and RESET.
module proj_sched_ctrl
    import muxp_pkg::*;
#(
    parameter int N_PROJ       = 32,
    parameter int DIV          = 2,
    parameter int RST_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    proj_sched_ctrl_if.slave   bus
);
    localparam int SEL_W   = $clog2(N_PROJ);
    localparam int CNT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   cur_sel, cur_sel_nxt;
    logic [CNT_W-1:0]   seq_cnt, seq_cnt_nxt;
    logic               sel_err_nxt;
    logic               accept;
    logic               bad_sel;
    logic               force_low;
    logic               run_st;
    logic               period_done;
    logic               gen_clk;
    logic [N_PROJ-1:0]  ena_nxt;
    logic [OW_W-1:0]    ow_nxt;
    logic [OW_W-1:0]    ow_arr [N_PROJ];

    logic [N_PROJ-1:0]  ena_q;
    logic               rstn_q;
    logic               ready_q;
    logic               running_q;
    logic               err_q;
    logic [OW_W-1:0]    ow_q;
    logic [7:0]         ui_q;
    logic [7:0]         uio_q;
    logic [IW_W-1:0]    iw;

    for (genvar g = 0; g < N_PROJ; g++) begin : g_ow
        assign ow_arr[g] = bus.proj_ow[g*OW_W +: OW_W];
    end

    assign accept    = bus.req_valid & ready_q;
    assign bad_sel   = 32'(bus.req_sel) >= N_PROJ;
    // Clock is pulled low in the same cycle a switch is accepted, so the DRAIN entry sees it low.
    assign force_low = (state == IDLE) || (state == DRAIN) || accept;
    assign run_st    = (state == RUN);

    proj_clk_gen #(
        .DIV(DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .run         (run_st),
        .force_low   (force_low),
        .step_mode   (bus.step_mode),
        .step        (bus.step),
        .proj_clk    (gen_clk),
        .period_done (period_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_sel <= '0;
            seq_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cur_sel <= cur_sel_nxt;
            seq_cnt <= seq_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cur_sel_nxt = cur_sel;
        seq_cnt_nxt = seq_cnt;
        sel_err_nxt = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    seq_cnt_nxt = '0;
                    if (bad_sel) begin
                        state_nxt   = IDLE;
                        sel_err_nxt = 1'b1;
                    end else begin
                        state_nxt   = DRAIN;
                        cur_sel_nxt = bus.req_sel;
                    end
                end
            end
            DRAIN: begin
                if (seq_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt   = RESET;
                    seq_cnt_nxt = '0;
                end else begin
                    seq_cnt_nxt = seq_cnt + CNT_W'(1);
                end
            end
            RESET: begin
                // The last reset period ends on a falling proj_clk edge, exactly at RUN entry.
                if (period_done) begin
                    if (seq_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state_nxt   = RUN;
                        seq_cnt_nxt = '0;
                    end else begin
                        seq_cnt_nxt = seq_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ena_nxt = '0;
        if (state_nxt == RESET || state_nxt == RUN) begin
            ena_nxt[cur_sel_nxt] = 1'b1;
        end
        ow_nxt = '0;
        if (state == RUN && state_nxt == RUN) begin
            ow_nxt = ow_arr[cur_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_q     <= '0;
            rstn_q    <= 1'b0;
            ready_q   <= 1'b1;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            ow_q      <= '0;
            ui_q      <= '0;
            uio_q     <= '0;
        end else begin
            ena_q     <= ena_nxt;
            rstn_q    <= (state_nxt == RUN);
            ready_q   <= (state_nxt == IDLE) || (state_nxt == RUN);
            running_q <= (state_nxt == RUN);
            err_q     <= sel_err_nxt;
            ow_q      <= ow_nxt;
            ui_q      <= bus.ui_in;
            uio_q     <= bus.uio_in;
        end
    end

    always_comb begin
        iw                        = '0;
        iw[IW_CLK]                = gen_clk;
        iw[IW_RSTN]               = rstn_q;
        iw[IW_UI_LSB +: 8]        = ui_q;
        iw[IW_UIO_LSB +: 8]       = uio_q;
    end

    assign bus.proj_iw   = iw;
    assign bus.proj_ena  = ena_q;
    assign bus.req_ready = ready_q;
    assign bus.running   = running_q;
    assign bus.sel_err   = err_q;
    assign bus.cur_sel   = cur_sel;
    assign bus.out_ow    = ow_q;

endmodule

// File: tb/tb_proj_sched_ctrl.sv
// Directed bench for proj_sched_ctrl: switch timelines, ow mux, select errors,
// single-step clocking and asynchronous reset.
module tb_proj_sched_ctrl;
    import muxp_pkg::*;

    localparam int N    = 24;
    localparam int SW   = $clog2(N);
    localparam int DRN  = 2;
    localparam int RLEN = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [OW_W-1:0] ow_slots [N];

    typedef struct {
        logic [7:0]    ui;
        logic [7:0]    uio;
        logic [SW-1:0] slot;
        logic [23:0]   val;
        logic [15:0]   exp_iw;
        logic [23:0]   exp_ow;
    } vec_t;

    vec_t vecs [6];
    bit   step_exp [14];

    always #5 clk = ~clk;

    proj_sched_ctrl_if #(.N_PROJ(N)) bus ();

    for (genvar g = 0; g < N; g++) begin : g_ow
        assign bus.proj_ow[g*OW_W +: OW_W] = ow_slots[g];
    end

    proj_sched_ctrl #(
        .N_PROJ(N), .DIV(2), .RST_CYCLES(4), .DRAIN_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_switch(input logic [SW-1:0] sel);
        logic [N-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        chk("sw_ready_before", 32'(bus.req_ready), 1);
        bus.req_sel   = sel;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            chk("sw_ready",   32'(bus.req_ready), (i <= DRN + RLEN) ? 0 : 1);
            chk("sw_ena",     32'(bus.proj_ena), (i > DRN) ? 32'(oh) : 0);
            chk("sw_rstn",    32'(bus.proj_iw[IW_RSTN]), (i > DRN + RLEN) ? 1 : 0);
            chk("sw_running", 32'(bus.running), (i > DRN + RLEN) ? 1 : 0);
            chk("sw_clk",     32'(bus.proj_iw[IW_CLK]), (i <= DRN) ? 0 : ((i - DRN - 1) / 2) % 2);
            chk("sw_out_ow",  32'(bus.out_ow), (i > DRN + RLEN + 1) ? 32'(ow_slots[sel]) : 0);
            chk("sw_cur_sel", 32'(bus.cur_sel), 32'(sel));
            chk("sw_sel_err", 32'(bus.sel_err), 0);
            tick();
        end
    endtask

    task automatic bad_req(input logic [SW-1:0] sel, input logic [SW-1:0] keep);
        bus.req_sel   = sel;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("err_pulse",   32'(bus.sel_err), 1);
        chk("err_ena",     32'(bus.proj_ena), 0);
        chk("err_running", 32'(bus.running), 0);
        chk("err_ready",   32'(bus.req_ready), 1);
        chk("err_cur_sel", 32'(bus.cur_sel), 32'(keep));
        chk("err_out_ow",  32'(bus.out_ow), 0);
        tick();
        chk("err_pulse_end", 32'(bus.sel_err), 0);
        chk("err_ready_idle", 32'(bus.req_ready), 1);
    endtask

    initial begin
        vecs[0] = '{8'h81, 8'h7E, 5'd5, 24'hA5C33C, 16'h7E81, 24'hA5C33C};
        vecs[1] = '{8'h00, 8'hFF, 5'd4, 24'hFFFFFF, 16'hFF00, 24'h000000};
        vecs[2] = '{8'h5A, 8'h3C, 5'd6, 24'h123456, 16'h3C5A, 24'h000000};
        vecs[3] = '{8'hFF, 8'h00, 5'd5, 24'h000001, 16'h00FF, 24'h000001};
        vecs[4] = '{8'h12, 8'h34, 5'd5, 24'h800000, 16'h3412, 24'h800000};
        vecs[5] = '{8'h00, 8'h00, 5'd0, 24'h0F0F0F, 16'h0000, 24'h000000};
        step_exp = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

        bus.req_valid = 1'b0;
        bus.req_sel   = '0;
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
        bus.ui_in     = '0;
        bus.uio_in    = '0;
        for (int k = 0; k < N; k++) ow_slots[k] = '0;

        #1 rst = 1'b1;
        #1;
        chk("rst_ena",     32'(bus.proj_ena), 0);
        chk("rst_iw",      32'(bus.proj_iw), 0);
        chk("rst_out_ow",  32'(bus.out_ow), 0);
        chk("rst_ready",   32'(bus.req_ready), 1);
        chk("rst_sel_err", 32'(bus.sel_err), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_cur_sel", 32'(bus.cur_sel), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ena",   32'(bus.proj_ena), 0);
        chk("idle_ready", 32'(bus.req_ready), 1);

        bus.ui_in  = 8'h81;
        bus.uio_in = 8'h7E;
        tick();
        chk("idle_iw_hi", 32'(bus.proj_iw[IW_UI_LSB +: 16]), 32'h7E81);
        chk("idle_iw_lo", 32'(bus.proj_iw[1:0]), 0);

        do_switch(5'd5);

        for (int v = 0; v < 6; v++) begin
            bus.ui_in  = vecs[v].ui;
            bus.uio_in = vecs[v].uio;
            for (int k = 0; k < N; k++) ow_slots[k] = '0;
            ow_slots[vecs[v].slot] = vecs[v].val;
            tick();
            chk("vec_iw_hi", 32'(bus.proj_iw[IW_UI_LSB +: 16]), 32'(vecs[v].exp_iw));
            chk("vec_rstn",  32'(bus.proj_iw[IW_RSTN]), 1);
            chk("vec_uo",    32'(bus.out_ow[OW_UO_LSB +: 8]),  32'(vecs[v].exp_ow[OW_UO_LSB +: 8]));
            chk("vec_uio",   32'(bus.out_ow[OW_UIO_LSB +: 8]), 32'(vecs[v].exp_ow[OW_UIO_LSB +: 8]));
            chk("vec_oe",    32'(bus.out_ow[OW_OE_LSB +: 8]),  32'(vecs[v].exp_ow[OW_OE_LSB +: 8]));
        end

        for (int k = 0; k < N; k++) ow_slots[k] = '0;
        ow_slots[5]  = 24'hA5C33C;
        ow_slots[7]  = 24'h00C0DE;
        ow_slots[3]  = 24'h3C3C3C;
        ow_slots[23] = 24'hFEDCBA;
        tick();
        chk("run5_out_ow", 32'(bus.out_ow), 32'hA5C33C);

        do_switch(5'd7);
        do_switch(5'd3);
        do_switch(5'd3);
        bad_req(5'd24, 5'd3);
        bad_req(5'd31, 5'd3);
        do_switch(5'd23);

        bus.step_mode = 1'b1;
        repeat (6) tick();
        for (int k = 0; k < 3; k++) begin
            chk("step_idle_low", 32'(bus.proj_iw[IW_CLK]), 0);
            chk("step_running",  32'(bus.running), 1);
            tick();
        end
        for (int c = 0; c < 14; c++) begin
            bus.step = (c == 0 || c == 2 || c == 4 || c == 9);
            chk("step_clk", 32'(bus.proj_iw[IW_CLK]), 32'(step_exp[c]));
            tick();
        end
        bus.step      = 1'b0;
        bus.step_mode = 1'b0;

        bus.ui_in     = 8'h81;
        bus.uio_in    = 8'h7E;
        bus.req_sel   = 5'd2;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_ena",   32'(bus.proj_ena), 32'h4);
        chk("pre_rst_ready", 32'(bus.req_ready), 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_ena",     32'(bus.proj_ena), 0);
        chk("arst_iw",      32'(bus.proj_iw), 0);
        chk("arst_out_ow",  32'(bus.out_ow), 0);
        chk("arst_ready",   32'(bus.req_ready), 1);
        chk("arst_running", 32'(bus.running), 0);
        chk("arst_cur_sel", 32'(bus.cur_sel), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("post_rst_ready",   32'(bus.req_ready), 1);
        chk("post_rst_running", 32'(bus.running), 0);
        chk("post_rst_ena",     32'(bus.proj_ena), 0);
        chk("post_rst_iw",      32'(bus.proj_iw), 32'h1FA04);
        tick();
        chk("post_rst_idle", 32'(bus.req_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
